// File: rtl/qpc_table.sv
// qpc_table: per-QP connection context store with registered, back-pressurable lookup and write forwarding
module qpc_table #(
   parameter int MAX_QP       = 256,
   parameter int QP_PTR_WIDTH = $clog2(MAX_QP)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_qpc_hdr_lookup_valid,
   output logic                    o_qpc_hdr_lookup_ready,
   input  logic [QP_PTR_WIDTH-1:0] i_qpc_hdr_lookup_qp_id,
   output logic                    o_qpc_valid,
   input  logic                    i_qpc_ready,
   output logic [QP_PTR_WIDTH-1:0] o_qpc_qp_id,
   output logic                    o_qpc_err,
   output logic [15:0]             o_qpc_pkey,
   output logic [2:0]              o_qpc_pmtu,
   output logic [23:0]             o_qpc_dest_qpid,
   output logic [23:0]             o_qpc_sq_curr_psn,
   output logic [23:0]             o_qpc_sq_curr_msn,
   output logic [127:0]            o_qpc_dest_ip,
   output logic [7:0]              o_qpc_ttl,
   output logic [5:0]              o_qpc_dscp,
   output logic [47:0]             o_qpc_dest_mac,
   input  logic                    i_qpc_hdr_update_valid,
   input  logic [QP_PTR_WIDTH-1:0] i_qpc_hdr_update_qpid,
   input  logic [23:0]             i_qpc_sq_curr_psn,
   input  logic [23:0]             i_qpc_sq_curr_msn,
   input  logic                    i_cfg_valid,
   input  logic [QP_PTR_WIDTH-1:0] i_cfg_qpid,
   input  logic                    i_cfg_enable,
   input  logic [15:0]             i_cfg_pkey,
   input  logic [2:0]              i_cfg_pmtu,
   input  logic [23:0]             i_cfg_dest_qpid,
   input  logic [127:0]            i_cfg_dest_ip,
   input  logic [7:0]              i_cfg_ttl,
   input  logic [5:0]              i_cfg_dscp,
   input  logic [47:0]             i_cfg_dest_mac,
   input  logic [23:0]             i_cfg_init_psn
);
   typedef struct packed {
      logic [15:0]  pkey;
      logic [2:0]   pmtu;
      logic [23:0]  dest_qpid;
      logic [127:0] dest_ip;
      logic [7:0]   ttl;
      logic [5:0]   dscp;
      logic [47:0]  dest_mac;
   } ctx_t;
   typedef struct packed {
      logic        err;
      ctx_t        s;
      logic [23:0] psn;
      logic [23:0] msn;
   } rsp_t;

   ctx_t              ctx_mem [MAX_QP];
   logic [23:0]       psn_mem [MAX_QP];
   logic [23:0]       msn_mem [MAX_QP];
   logic [MAX_QP-1:0] en;

   logic                    valid_q;
   logic [QP_PTR_WIDTH-1:0] qp_id_q;
   rsp_t                    rsp_q;
   rsp_t                    nxt;
   ctx_t                    cfg_ctx;
   ctx_t                    rd_ctx;
   logic                    lk_acc, cfg_hit, upd_we, upd_hit, rd_en;
   logic [23:0]             rd_psn, rd_msn;

   assign cfg_ctx = '{pkey: i_cfg_pkey, pmtu: i_cfg_pmtu, dest_qpid: i_cfg_dest_qpid,
                      dest_ip: i_cfg_dest_ip, ttl: i_cfg_ttl, dscp: i_cfg_dscp,
                      dest_mac: i_cfg_dest_mac};

   assign o_qpc_hdr_lookup_ready = ~valid_q | i_qpc_ready;
   assign lk_acc  = i_qpc_hdr_lookup_valid & o_qpc_hdr_lookup_ready;
   // Config to the same QP in the same cycle overrides the update
   assign upd_we  = i_qpc_hdr_update_valid & en[i_qpc_hdr_update_qpid] &
                    ~(i_cfg_valid & (i_cfg_qpid == i_qpc_hdr_update_qpid));
   assign cfg_hit = i_cfg_valid & (i_cfg_qpid == i_qpc_hdr_lookup_qp_id);
   assign upd_hit = upd_we & (i_qpc_hdr_update_qpid == i_qpc_hdr_lookup_qp_id);

   assign rd_en  = cfg_hit ? i_cfg_enable : en[i_qpc_hdr_lookup_qp_id];
   assign rd_ctx = cfg_hit ? cfg_ctx : ctx_mem[i_qpc_hdr_lookup_qp_id];
   assign rd_psn = cfg_hit ? i_cfg_init_psn :
                   upd_hit ? i_qpc_sq_curr_psn : psn_mem[i_qpc_hdr_lookup_qp_id];
   assign rd_msn = cfg_hit ? 24'd0 :
                   upd_hit ? i_qpc_sq_curr_msn : msn_mem[i_qpc_hdr_lookup_qp_id];

   assign nxt.err = ~rd_en;
   assign nxt.s   = rd_en ? rd_ctx : '0;
   assign nxt.psn = rd_en ? rd_psn : '0;
   assign nxt.msn = rd_en ? rd_msn : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en <= '0;
      end else if (i_cfg_valid) begin
         en[i_cfg_qpid] <= i_cfg_enable;
      end
   end

   always_ff @(posedge clk) begin
      if (i_cfg_valid) begin
         ctx_mem[i_cfg_qpid] <= cfg_ctx;
         psn_mem[i_cfg_qpid] <= i_cfg_init_psn;
         msn_mem[i_cfg_qpid] <= 24'd0;
      end
      if (upd_we) begin
         psn_mem[i_qpc_hdr_update_qpid] <= i_qpc_sq_curr_psn;
         msn_mem[i_qpc_hdr_update_qpid] <= i_qpc_sq_curr_msn;
      end
   end

   // Single-entry output stage; fields hold their last value after drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         qp_id_q <= '0;
         rsp_q   <= '0;
      end else if (lk_acc) begin
         valid_q <= 1'b1;
         qp_id_q <= i_qpc_hdr_lookup_qp_id;
         rsp_q   <= nxt;
      end else if (i_qpc_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign o_qpc_valid       = valid_q;
   assign o_qpc_qp_id       = qp_id_q;
   assign o_qpc_err         = rsp_q.err;
   assign o_qpc_pkey        = rsp_q.s.pkey;
   assign o_qpc_pmtu        = rsp_q.s.pmtu;
   assign o_qpc_dest_qpid   = rsp_q.s.dest_qpid;
   assign o_qpc_dest_ip     = rsp_q.s.dest_ip;
   assign o_qpc_ttl         = rsp_q.s.ttl;
   assign o_qpc_dscp        = rsp_q.s.dscp;
   assign o_qpc_dest_mac    = rsp_q.s.dest_mac;
   assign o_qpc_sq_curr_psn = rsp_q.psn;
   assign o_qpc_sq_curr_msn = rsp_q.msn;
endmodule

// File: tb/tb_qpc_table.sv
// tb_qpc_table: directed self-checking bench for qpc_table
module tb_qpc_table;
   localparam int N = 256;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          lk_valid, lk_ready;
   logic [W-1:0]  lk_id;
   logic          o_valid, qpc_ready;
   logic [W-1:0]  o_qp_id;
   logic          o_err;
   logic [15:0]   o_pkey;
   logic [2:0]    o_pmtu;
   logic [23:0]   o_dest_qpid, o_psn, o_msn;
   logic [127:0]  o_dest_ip;
   logic [7:0]    o_ttl;
   logic [5:0]    o_dscp;
   logic [47:0]   o_dest_mac;
   logic          upd_valid;
   logic [W-1:0]  upd_qpid;
   logic [23:0]   upd_psn, upd_msn;
   logic          cfg_valid, cfg_enable;
   logic [W-1:0]  cfg_qpid;
   logic [15:0]   cfg_pkey;
   logic [2:0]    cfg_pmtu;
   logic [23:0]   cfg_dest_qpid, cfg_init_psn;
   logic [127:0]  cfg_dest_ip;
   logic [7:0]    cfg_ttl;
   logic [5:0]    cfg_dscp;
   logic [47:0]   cfg_dest_mac;

   logic [N-1:0]  en_model;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   qpc_table #(.MAX_QP(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_qpc_hdr_lookup_valid(lk_valid), .o_qpc_hdr_lookup_ready(lk_ready),
      .i_qpc_hdr_lookup_qp_id(lk_id),
      .o_qpc_valid(o_valid), .i_qpc_ready(qpc_ready), .o_qpc_qp_id(o_qp_id),
      .o_qpc_err(o_err), .o_qpc_pkey(o_pkey), .o_qpc_pmtu(o_pmtu),
      .o_qpc_dest_qpid(o_dest_qpid), .o_qpc_sq_curr_psn(o_psn), .o_qpc_sq_curr_msn(o_msn),
      .o_qpc_dest_ip(o_dest_ip), .o_qpc_ttl(o_ttl), .o_qpc_dscp(o_dscp),
      .o_qpc_dest_mac(o_dest_mac),
      .i_qpc_hdr_update_valid(upd_valid), .i_qpc_hdr_update_qpid(upd_qpid),
      .i_qpc_sq_curr_psn(upd_psn), .i_qpc_sq_curr_msn(upd_msn),
      .i_cfg_valid(cfg_valid), .i_cfg_qpid(cfg_qpid), .i_cfg_enable(cfg_enable),
      .i_cfg_pkey(cfg_pkey), .i_cfg_pmtu(cfg_pmtu), .i_cfg_dest_qpid(cfg_dest_qpid),
      .i_cfg_dest_ip(cfg_dest_ip), .i_cfg_ttl(cfg_ttl), .i_cfg_dscp(cfg_dscp),
      .i_cfg_dest_mac(cfg_dest_mac), .i_cfg_init_psn(cfg_init_psn)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_set(input int q, input logic e, input logic [15:0] pkey,
                          input logic [2:0] pmtu, input logic [23:0] dqp,
                          input logic [23:0] psn, input logic [47:0] mac);
      cfg_valid     = 1'b1;
      cfg_qpid      = W'(q);
      cfg_enable    = e;
      cfg_pkey      = pkey;
      cfg_pmtu      = pmtu;
      cfg_dest_qpid = dqp;
      cfg_init_psn  = psn;
      cfg_dest_mac  = mac;
      cfg_dest_ip   = {32'hC0A8_0000 + 32'(q), 96'h1};
      cfg_ttl       = 8'd64;
      cfg_dscp      = 6'd10;
      en_model[q]   = e;
   endtask

   initial begin
      rst_n = 1'b0; en_model = '0;
      lk_valid = 0; lk_id = '0; qpc_ready = 1;
      upd_valid = 0; upd_qpid = '0; upd_psn = '0; upd_msn = '0;
      cfg_valid = 0; cfg_qpid = '0; cfg_enable = 0; cfg_pkey = '0; cfg_pmtu = '0;
      cfg_dest_qpid = '0; cfg_init_psn = '0; cfg_dest_ip = '0; cfg_ttl = '0;
      cfg_dscp = '0; cfg_dest_mac = '0;
      tick(); tick();
      chk("rst_valid", 128'(o_valid), 0);
      chk("rst_err", 128'(o_err), 0);
      chk("rst_qp_id", 128'(o_qp_id), 0);
      chk("rst_pkey", 128'(o_pkey), 0);
      chk("rst_ready", 128'(lk_ready), 1);
      rst_n = 1'b1;
      tick();

      // lookup of an unconfigured QP
      lk_valid = 1; lk_id = 8'd5;
      tick();
      lk_valid = 0;
      chk("dis_valid", 128'(o_valid), 1);
      chk("dis_err", 128'(o_err), 1);
      chk("dis_qp_id", 128'(o_qp_id), 5);
      chk("dis_pkey", 128'(o_pkey), 0);
      chk("dis_psn", 128'(o_psn), 0);
      chk("dis_mac", 128'(o_dest_mac), 0);
      tick();
      chk("drain_valid", 128'(o_valid), 0);

      cfg_set(5, 1, 16'hFFFF, 3'b100, 24'h000123, 24'h000100, 48'h0011_2233_4455);
      tick();
      cfg_valid = 0;
      lk_valid = 1; lk_id = 8'd5;
      tick();
      lk_valid = 0;
      chk("cfg5_err", 128'(o_err), 0);
      chk("cfg5_pkey", 128'(o_pkey), 16'hFFFF);
      chk("cfg5_pmtu", 128'(o_pmtu), 3'b100);
      chk("cfg5_dqp", 128'(o_dest_qpid), 24'h000123);
      chk("cfg5_psn", 128'(o_psn), 24'h000100);
      chk("cfg5_msn", 128'(o_msn), 0);
      chk("cfg5_ttl", 128'(o_ttl), 64);
      chk("cfg5_mac", 128'(o_dest_mac), 48'h0011_2233_4455);
      chk("cfg5_ip", o_dest_ip, {32'hC0A8_0005, 96'h1});

      // config forwarded to a same-cycle lookup
      cfg_set(7, 1, 16'h7777, 3'b011, 24'h000777, 24'h000042, 48'hAAAA_0000_0007);
      lk_valid = 1; lk_id = 8'd7;
      tick();
      cfg_valid = 0; lk_valid = 0;
      chk("fwdcfg_err", 128'(o_err), 0);
      chk("fwdcfg_pkey", 128'(o_pkey), 16'h7777);
      chk("fwdcfg_psn", 128'(o_psn), 24'h000042);

      // update forwarded to a same-cycle lookup, then persisted
      upd_valid = 1; upd_qpid = 8'd5; upd_psn = 24'h000200; upd_msn = 24'h000007;
      lk_valid = 1; lk_id = 8'd5;
      tick();
      upd_valid = 0;
      chk("fwdupd_psn", 128'(o_psn), 24'h000200);
      chk("fwdupd_msn", 128'(o_msn), 24'h000007);
      tick();
      lk_valid = 0;
      chk("upd_psn", 128'(o_psn), 24'h000200);
      chk("upd_msn", 128'(o_msn), 24'h000007);
      chk("upd_pkey", 128'(o_pkey), 16'hFFFF);

      // config and update to the same QP: config wins
      cfg_set(9, 1, 16'h9999, 3'b001, 24'h000009, 24'h000010, 48'h9);
      upd_valid = 1; upd_qpid = 8'd9; upd_psn = 24'h000055; upd_msn = 24'h000003;
      tick();
      cfg_valid = 0; upd_valid = 0;
      lk_valid = 1; lk_id = 8'd9;
      tick();
      lk_valid = 0;
      chk("cfgwin_psn", 128'(o_psn), 24'h000010);
      chk("cfgwin_msn", 128'(o_msn), 0);

      // config and update to different QPs in one cycle both land
      cfg_set(1, 1, 16'h1111, 3'b010, 24'h000001, 24'h000011, 48'h1);
      upd_valid = 1; upd_qpid = 8'd7; upd_psn = 24'h000abc; upd_msn = 24'h000002;
      tick();
      upd_valid = 0;
      cfg_set(2, 1, 16'h2222, 3'b010, 24'h000002, 24'h000022, 48'h2);
      tick();
      cfg_valid = 0;
      lk_valid = 1; lk_id = 8'd7;
      tick();
      lk_valid = 0;
      chk("both_psn7", 128'(o_psn), 24'h000abc);
      chk("both_msn7", 128'(o_msn), 24'h000002);

      // destroy QP 9, and an update to a disabled QP has no effect on the error path
      cfg_set(9, 0, 16'h9999, 3'b001, 24'h000009, 24'h000010, 48'h9);
      tick();
      cfg_valid = 0;
      upd_valid = 1; upd_qpid = 8'd9; upd_psn = 24'h000066;
      lk_valid = 1; lk_id = 8'd9;
      tick();
      upd_valid = 0; lk_valid = 0;
      chk("destroy_err", 128'(o_err), 1);
      chk("destroy_psn", 128'(o_psn), 0);
      chk("destroy_pkey", 128'(o_pkey), 0);
      tick();

      // back-pressure: QP 1 held, QP 2 waits
      qpc_ready = 0; lk_valid = 1; lk_id = 8'd1;
      tick();
      lk_id = 8'd2;
      chk("bp_ready0", 128'(lk_ready), 0);
      cfg_set(1, 1, 16'hABCD, 3'b010, 24'h000001, 24'h000011, 48'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         cfg_valid = 0;
         chk("bp_hold_valid", 128'(o_valid), 1);
         chk("bp_hold_qp", 128'(o_qp_id), 1);
         chk("bp_hold_pkey", 128'(o_pkey), 16'h1111);
      end
      qpc_ready = 1;
      #1;
      chk("bp_ready1", 128'(lk_ready), 1);
      tick();
      lk_valid = 0;
      chk("bp_next_valid", 128'(o_valid), 1);
      chk("bp_next_qp", 128'(o_qp_id), 2);
      chk("bp_next_pkey", 128'(o_pkey), 16'h2222);
      tick();
      chk("bp_nodup", 128'(o_valid), 0);
      chk("bp_fields_hold", 128'(o_qp_id), 2);

      // full sweep at one lookup per cycle
      cfg_set(N-1, 1, 16'h00FF, 3'b101, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FFFF_FFFF);
      tick();
      cfg_valid = 0;
      lk_valid = 1;
      for (int i = 0; i < N; i++) begin
         lk_id = W'(i);
         #1;
         chk("sweep_ready", 128'(lk_ready), 1);
         tick();
         chk("sweep_qp", 128'(o_qp_id), 128'(i));
         chk("sweep_err", 128'(o_err), 128'(!en_model[i]));
      end
      lk_valid = 0;
      chk("sweep_mac", 128'(o_dest_mac), 48'hFFFF_FFFF_FFFF);
      chk("sweep_pkey", 128'(o_pkey), 16'h00FF);
      tick();

      // reset while a response is held
      qpc_ready = 0; lk_valid = 1; lk_id = 8'd5;
      tick();
      lk_valid = 0;
      chk("mid_valid", 128'(o_valid), 1);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", 128'(o_valid), 0);
      chk("mid_rst_pkey", 128'(o_pkey), 0);
      tick();
      rst_n = 1; qpc_ready = 1;
      tick();
      lk_valid = 1; lk_id = 8'd5;
      tick();
      lk_valid = 0;
      chk("post_rst_err", 128'(o_err), 1);
      chk("post_rst_psn", 128'(o_psn), 0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/qpc_table.md
# qpc_table

Parametrised QP-context store for the TX header path, a successor to the fixed-value lookup agent. It holds per-QP static connection fields, written through a configuration port, and dynamic SQ PSN/MSN state, updated by the header builder. Lookups get a registered, back-pressurable response with same-cycle write forwarding. It sits between the TX scheduler/header builder and the packet-header generator.

## Interface
- MAX_QP, 256, number of QP contexts.
- QP_PTR_WIDTH, $clog2(MAX_QP), QP index width; must be ≤ 24.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_qpc_hdr_lookup_valid  in  1  lookup request.
- o_qpc_hdr_lookup_ready  out  1  lookup accepted when valid&ready.
- i_qpc_hdr_lookup_qp_id  in  QP_PTR_WIDTH  QP to read.
- o_qpc_valid  out  1  response valid, held until i_qpc_ready.
- i_qpc_ready  in  1  downstream accepts response.
- o_qpc_qp_id  out  QP_PTR_WIDTH  echoed lookup index.
- o_qpc_err  out  1  looked-up QP not enabled; fields are zero.
- o_qpc_pkey 16, o_qpc_pmtu 3, o_qpc_dest_qpid 24, o_qpc_sq_curr_psn 24, o_qpc_sq_curr_msn 24, o_qpc_dest_ip 128, o_qpc_ttl 8, o_qpc_dscp 6, o_qpc_dest_mac 48  out  context fields.
- i_qpc_hdr_update_valid  in  1  PSN/MSN write (always accepted).
- i_qpc_hdr_update_qpid  in  QP_PTR_WIDTH  QP to update.
- i_qpc_sq_curr_psn, i_qpc_sq_curr_msn  in  24 each  new values.
- i_cfg_valid  in  1  context write (always accepted).
- i_cfg_qpid  in  QP_PTR_WIDTH  target QP.
- i_cfg_enable  in  1  1 = create/modify QP, 0 = destroy.
- i_cfg_pkey, i_cfg_pmtu, i_cfg_dest_qpid, i_cfg_dest_ip, i_cfg_ttl, i_cfg_dscp, i_cfg_dest_mac  in  field widths as outputs  static fields.
- i_cfg_init_psn  in  24  initial PSN; MSN initialises to 0.

## Operation
- Storage: per-QP enable bit (reset to 0), static-field array, PSN array, MSN array. Data arrays are not reset.
- Config write: stores every static field, sets enable = i_cfg_enable, PSN = i_cfg_init_psn, MSN = 0.
- Update write: stores PSN/MSN at i_qpc_hdr_update_qpid. It is ignored (no write) if that QP is disabled. It is also ignored if a config write targets the same QP in the same cycle; config wins.
- Config and update to different QPs in the same cycle: both are performed.
- Lookup: reads the enable bit and all fields combinationally, then registers them into the output stage. If the QP is disabled, o_qpc_err = 1 and all field outputs are 0.
- Forwarding, when a lookup is accepted in the same cycle as a write to the same QP:
  - A config write forwards all config values, including enable/err.
  - Otherwise an update to an enabled QP forwards the update PSN/MSN.
  - The response therefore never returns stale data.
- Output stage is one entry. o_qpc_hdr_lookup_ready = ~o_qpc_valid | i_qpc_ready, so full throughput is one lookup per cycle. A held response is frozen, and later writes do not change it.

## Timing
- Reset (async assert, sync use after deassert):
  - o_qpc_valid = 0, o_qpc_err = 0, o_qpc_qp_id = 0, all field outputs = 0.
  - All enable bits = 0.
- Lookup accepted at edge N: response is visible after edge N, i.e. o_qpc_valid = 1 in cycle N+1.
- Writes at edge N are visible to lookups accepted at edge N (forwarded) and all later lookups.
- Response held while o_qpc_valid & ~i_qpc_ready. Accept-and-drain in the same cycle loads the new response with no bubble.
- No lookup accepted and response drained: o_qpc_valid falls at the next edge. Field outputs hold their last value.
- Reset mid-operation: a pending response is dropped and all QPs become disabled.

## Test plan
- Reset, then lookup QP 5 -> o_qpc_valid=1 one cycle later, o_qpc_err=1, all fields 0.
- Config QP 5 (pkey 0xFFFF, pmtu 3'b100, dest_qpid 0x000123, init_psn 0x000100), then lookup QP 5 -> err=0, pkey 0xFFFF, pmtu 3'b100, psn 0x000100, msn 0.
- Update QP 5 psn 0x000200 / msn 0x000007 in the same cycle as a lookup of QP 5 -> response psn 0x000200, msn 0x000007. Next lookup returns the same values.
- Same cycle: config QP 9 (init_psn 0x10) and update QP 9 (psn 0x55) -> later lookup of QP 9 returns psn 0x10.
- Hold i_qpc_ready=0 for 3 cycles with lookup_valid high for QPs 1, 2 -> ready=0; QP 1 response stable; on ready=1, QP 2 returns the next cycle and no lookup is lost or duplicated.
- Back-to-back lookups of QPs 0..MAX_QP-1 (QP MAX_QP-1 configured with dest_mac 0xFFFFFFFFFFFF) with ready=1 -> one response per cycle, indices in order, and QP MAX_QP-1 returns the correct MAC.
